// File: rtl/cve2_multdiv_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: operator encoding and FSM states.
package cve2_multdiv_iter_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [2:0] {
    MDI_IDLE,
    MDI_MUL,
    MDI_DIV,
    MDI_FIX,
    MDI_DONE
  } multdiv_iter_state_e;

  function automatic logic is_mul_op(input md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/cve2_multdiv_iter_if.sv
// Request/response handshake bundle between the EX stage and the iterative multdiv unit.
interface cve2_multdiv_iter_if #(
  parameter int WIDTH = 32
);
  import cve2_multdiv_iter_pkg::*;

  logic             in_valid;
  logic             in_ready;
  md_op_e           operator;
  logic [1:0]       signed_mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             data_ind_timing;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, operator, signed_mode, op_a, op_b, data_ind_timing, kill, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, operator, signed_mode, op_a, op_b, data_ind_timing, kill, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/cve2_multdiv_iter_dp.sv
// Combinational step datapath: shift-add for multiply, restoring compare-subtract for divide,
// and the final conditional two's-complement negate.
module cve2_multdiv_iter_dp #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic               mplr_lsb,
  input  logic [WIDTH:0]     rem,
  input  logic               dvd_msb,
  input  logic [WIDTH:0]     dvs,
  input  logic [2*WIDTH-1:0] fix_in,
  input  logic               fix_neg,
  output logic [2*WIDTH-1:0] acc_add,
  output logic [WIDTH:0]     rem_sub,
  output logic               q_bit,
  output logic [2*WIDTH-1:0] fix_out
);

  function automatic logic [2*WIDTH-1:0] cond_neg(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic [WIDTH:0]          rem_sh;
  logic signed [WIDTH+1:0] diff;

  assign acc_add = mplr_lsb ? (acc + mcand) : acc;

  // A negative difference means the shifted remainder is below the divisor.
  assign rem_sh  = {rem[WIDTH-1:0], dvd_msb};
  assign diff    = $signed({1'b0, rem_sh}) - $signed({1'b0, dvs});
  assign q_bit   = ~diff[WIDTH+1];
  assign rem_sub = q_bit ? diff[WIDTH:0] : rem_sh;

  assign fix_out = cond_neg(fix_in, fix_neg);

endmodule

// File: rtl/cve2_multdiv_iter.sv
// Iterative radix-2 multiply/divide unit with valid/ready on both sides, abort, early
// termination and a data-independent-timing mode.
module cve2_multdiv_iter
  import cve2_multdiv_iter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input logic                clk,
  input logic                rst,
  cve2_multdiv_iter_if.slave md
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    return {1'b0, (neg ? (~v + 1'b1) : v)};
  endfunction

  multdiv_iter_state_e state;
  md_op_e              op_q;
  logic                dit_q, neg_q, dz_q;
  logic [CNT_W-1:0]    cnt;
  logic [2*WIDTH-1:0]  mcand, acc;
  logic [WIDTH:0]      mplr;
  logic [WIDTH-1:0]    result;

  logic               accept, sign_a, sign_b, b_zero, mul_done;
  logic [WIDTH:0]     mag_a, mag_b, mplr_nxt, rem_sub;
  logic [2*WIDTH-1:0] acc_add, fix_in, fix_out;
  logic               q_bit;
  logic [WIDTH-1:0]   res_nxt;

  assign md.in_ready  = (state == MDI_IDLE) | ((state == MDI_DONE) & md.out_ready);
  assign md.out_valid = (state == MDI_DONE);
  assign md.busy      = (state != MDI_IDLE);
  assign md.result    = result;

  // Kill dominates a simultaneous request.
  assign accept   = md.in_valid & md.in_ready & ~md.kill;
  assign sign_a   = md.signed_mode[0] & md.op_a[WIDTH-1];
  assign sign_b   = md.signed_mode[1] & md.op_b[WIDTH-1];
  assign mag_a    = magnitude(md.op_a, sign_a);
  assign mag_b    = magnitude(md.op_b, sign_b);
  assign b_zero   = (md.op_b == '0);

  assign mplr_nxt = mplr >> 1;
  assign mul_done = (cnt == CNT_W'(1)) | (EARLY_TERM & ~dit_q & (mplr_nxt == '0));

  cve2_multdiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
    .acc      (acc),
    .mcand    (mcand),
    .mplr_lsb (mplr[0]),
    .rem      (acc[WIDTH:0]),
    .dvd_msb  (mcand[WIDTH-1]),
    .dvs      (mplr),
    .fix_in   (fix_in),
    .fix_neg  (neg_q),
    .acc_add  (acc_add),
    .rem_sub  (rem_sub),
    .q_bit    (q_bit),
    .fix_out  (fix_out)
  );

  // The quotient shifts into the low end of mcand as the dividend shifts out of it.
  always_comb begin
    fix_in  = acc;
    res_nxt = fix_out[WIDTH-1:0];
    case (op_q)
      MD_OP_MULL: fix_in = acc;
      MD_OP_MULH: begin
        fix_in  = acc;
        res_nxt = fix_out[2*WIDTH-1:WIDTH];
      end
      MD_OP_DIV: begin
        fix_in = {{WIDTH{1'b0}}, mcand[WIDTH-1:0]};
        if (dz_q) res_nxt = '1;
      end
      MD_OP_REM: fix_in = {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
      default:   fix_in = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MDI_IDLE;
      result <= '0;
    end else if (md.kill) begin
      state <= MDI_IDLE;
    end else if (accept) begin
      op_q  <= md.operator;
      dit_q <= md.data_ind_timing;
      dz_q  <= b_zero;
      neg_q <= (md.operator == MD_OP_REM) ? sign_a : (sign_a ^ sign_b);
      cnt   <= CNT_W'(WIDTH);
      mcand <= {{(WIDTH-1){1'b0}}, mag_a};
      mplr  <= mag_b;
      // A skipped divide-by-zero leaves the dividend magnitude where the remainder is read.
      if (!is_mul_op(md.operator) && b_zero && !md.data_ind_timing)
        acc <= {{(WIDTH-1){1'b0}}, mag_a};
      else
        acc <= '0;
      if (is_mul_op(md.operator))
        state <= (b_zero && !md.data_ind_timing) ? MDI_FIX : MDI_MUL;
      else
        state <= (b_zero && !md.data_ind_timing) ? MDI_FIX : MDI_DIV;
    end else begin
      case (state)
        MDI_MUL: begin
          acc   <= acc_add;
          mcand <= mcand << 1;
          mplr  <= mplr_nxt;
          cnt   <= cnt - 1'b1;
          if (mul_done) state <= MDI_FIX;
        end
        MDI_DIV: begin
          acc   <= {{(WIDTH-1){1'b0}}, rem_sub};
          mcand <= {mcand[2*WIDTH-2:0], q_bit};
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= MDI_FIX;
        end
        MDI_FIX: begin
          result <= res_nxt;
          state  <= MDI_DONE;
        end
        MDI_DONE: if (md.out_ready) state <= MDI_IDLE;
        default:  state <= MDI_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cve2_multdiv_iter.sv
// Directed bench for cve2_multdiv_iter (WIDTH=32, EARLY_TERM=1) with hand-computed results.
module tb_cve2_multdiv_iter;
  import cve2_multdiv_iter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cve2_multdiv_iter_if #(.WIDTH(32)) md_if ();

  cve2_multdiv_iter #(.WIDTH(32), .EARLY_TERM(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md_if.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                       input logic [31:0] b, input logic dit);
    md_if.operator        = op;
    md_if.signed_mode     = sm;
    md_if.op_a            = a;
    md_if.op_b            = b;
    md_if.data_ind_timing = dit;
    md_if.in_valid        = 1'b1;
  endtask

  // Counts the accept edge as cycle 1; stops at the edge where out_valid rises.
  task automatic wait_result(output logic [31:0] res, output int cyc);
    cyc = 1;
    while (!md_if.out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = md_if.result;
  endtask

  task automatic run_op(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                        input logic [31:0] b, input logic dit,
                        output logic [31:0] res, output int cyc);
    drive(op, sm, a, b, dit);
    @(posedge clk); #1;
    md_if.in_valid = 1'b0;
    wait_result(res, cyc);
  endtask

  task automatic take();
    md_if.out_ready = 1'b1;
    @(posedge clk); #1;
    md_if.out_ready = 1'b0;
  endtask

  task automatic op_check(input string tag, input md_op_e op, input logic [1:0] sm,
                          input logic [31:0] a, input logic [31:0] b, input logic dit,
                          input logic [31:0] exp_res, input int exp_cyc);
    logic [31:0] res;
    int          cyc;
    run_op(op, sm, a, b, dit, res, cyc);
    check({tag, "_valid"}, 64'(md_if.out_valid), 64'd1);
    check({tag, "_res"}, 64'(res), 64'(exp_res));
    check({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
    take();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, held;
    int          cyc, bad;

    rst                   = 1'b1;
    md_if.in_valid        = 1'b0;
    md_if.operator        = MD_OP_MULL;
    md_if.signed_mode     = 2'b00;
    md_if.op_a            = '0;
    md_if.op_b            = '0;
    md_if.data_ind_timing = 1'b0;
    md_if.kill            = 1'b0;
    md_if.out_ready       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(md_if.out_valid), 64'd0);
    check("rst_busy", 64'(md_if.busy), 64'd0);
    check("rst_result", 64'(md_if.result), 64'd0);
    check("rst_in_ready", 64'(md_if.in_ready), 64'd1);
    rst = 1'b0;

    op_check("mull_7x_m3", MD_OP_MULL, 2'b11, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 4);
    op_check("mulh_7x_m3_dit", MD_OP_MULH, 2'b11, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 34);
    op_check("mulhsu", MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFF, 4);
    op_check("mull_u", MD_OP_MULL, 2'b00, 32'h1234_5678, 32'h10, 1'b0, 32'h2345_6780, 7);
    op_check("mull_zero", MD_OP_MULL, 2'b11, 32'd5, 32'd0, 1'b0, 32'd0, 2);
    op_check("div_ovf", MD_OP_DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 34);
    op_check("rem_ovf", MD_OP_REM, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 34);
    op_check("div_m7_2", MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 34);
    op_check("rem_m7_2", MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 34);
    op_check("divu_z", MD_OP_DIV, 2'b00, 32'd100, 32'd0, 1'b0, 32'hFFFF_FFFF, 2);
    op_check("remu_z", MD_OP_REM, 2'b00, 32'd100, 32'd0, 1'b0, 32'h64, 2);
    op_check("divu_z_dit", MD_OP_DIV, 2'b00, 32'd100, 32'd0, 1'b1, 32'hFFFF_FFFF, 34);
    op_check("remu_z_dit", MD_OP_REM, 2'b00, 32'd100, 32'd0, 1'b1, 32'h64, 34);

    // Backpressure, then a new request accepted on the same edge the result is taken.
    run_op(MD_OP_MULL, 2'b11, 32'd7, 32'hFFFF_FFFD, 1'b0, held, cyc);
    check("bp_first", 64'(held), 64'hFFFF_FFEB);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (md_if.result !== held || md_if.out_valid !== 1'b1 || md_if.in_ready !== 1'b0) bad++;
    end
    check("bp_hold", 64'(bad), 64'd0);
    md_if.out_ready = 1'b1;
    drive(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 1'b0);
    #1;
    check("bp_in_ready", 64'(md_if.in_ready), 64'd1);
    @(posedge clk); #1;
    md_if.in_valid  = 1'b0;
    md_if.out_ready = 1'b0;
    check("b2b_busy", 64'(md_if.busy), 64'd1);
    check("b2b_valid", 64'(md_if.out_valid), 64'd0);
    wait_result(res, cyc);
    check("b2b_res", 64'(res), 64'd14);
    check("b2b_lat", 64'(cyc), 64'd34);
    take();

    // Kill during step 5 of a divide.
    drive(MD_OP_DIV, 2'b00, 32'd1000, 32'd3, 1'b0);
    @(posedge clk); #1;
    md_if.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    md_if.kill = 1'b1;
    @(posedge clk); #1;
    md_if.kill = 1'b0;
    check("kill_busy", 64'(md_if.busy), 64'd0);
    check("kill_in_ready", 64'(md_if.in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_if.out_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("kill_no_valid", 64'(bad), 64'd0);

    // Kill together with a request: the request is dropped.
    drive(MD_OP_MULL, 2'b00, 32'd3, 32'd3, 1'b0);
    md_if.kill = 1'b1;
    @(posedge clk); #1;
    md_if.in_valid = 1'b0;
    md_if.kill     = 1'b0;
    check("kill_accept_busy", 64'(md_if.busy), 64'd0);

    // Reset in the middle of a multiply; result register holds 14 beforehand.
    drive(MD_OP_MULL, 2'b00, 32'd9, 32'd9, 1'b1);
    @(posedge clk); #1;
    md_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(md_if.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_out_valid", 64'(md_if.out_valid), 64'd0);
    check("mrst_busy", 64'(md_if.busy), 64'd0);
    check("mrst_result", 64'(md_if.result), 64'd0);
    check("mrst_in_ready", 64'(md_if.in_ready), 64'd1);

    op_check("mulh_u_after_rst", MD_OP_MULH, 2'b00, 32'h1234_5678, 32'h10, 1'b0, 32'h1, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
